// File: rtl/autenticacao_pkg.sv
// Shared definitions for the authentication controller slice.
//   estado_t        : controller state encoding (2 bits)
//   NIVEL_*         : encoded access levels driven on nivel
//   LARGURA_CODIGO  : width of the entered code / comparator inputs A..F
//   LARGURA_AUT     : width of the comparator authorization vector
//   codifica_nivel  : priority encoder aut -> nivel (AUT3 highest)
package autenticacao_pkg;

  localparam int LARGURA_CODIGO = 6;
  localparam int LARGURA_AUT    = 3;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    AVALIA    = 2'd1,
    LIBERADO  = 2'd2,
    BLOQUEADO = 2'd3
  } estado_t;

  localparam logic [1:0] NIVEL_NENHUM = 2'd0;
  localparam logic [1:0] NIVEL_1      = 2'd1;
  localparam logic [1:0] NIVEL_2      = 2'd2;
  localparam logic [1:0] NIVEL_3      = 2'd3;

  // Highest matched level wins: aut[2] (AUT3) over aut[1] over aut[0].
  function automatic logic [1:0] codifica_nivel(input logic [LARGURA_AUT-1:0] aut);
    logic [1:0] nivel;
    nivel = NIVEL_NENHUM;
    if (aut[2])      nivel = NIVEL_3;
    else if (aut[1]) nivel = NIVEL_2;
    else if (aut[0]) nivel = NIVEL_1;
    return nivel;
  endfunction

endpackage

// File: rtl/temporizador_descendente.sv
// Loadable down-counter used for both the access window and the lockout.
//   clk, rst     : clock, asynchronous active-high reset (count -> 0)
//   carga        : load valor_carga this cycle (has priority over habilita)
//   valor_carga  : value to load
//   habilita     : count down by one per cycle, saturating at zero
//   zero         : count is zero
module temporizador_descendente #(
  parameter int LARGURA = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               carga,
  input  logic [LARGURA-1:0] valor_carga,
  input  logic               habilita,
  output logic               zero
);

  logic [LARGURA-1:0] valor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valor <= '0;
    end else if (carga) begin
      valor <= valor_carga;
    end else if (habilita && (valor != '0)) begin
      valor <= valor - LARGURA'(1);
    end
  end

  assign zero = (valor == '0);

endmodule

// File: rtl/controlador_autenticacao.sv
// Sequential controller in front of the external combinational comparator.
// Captures the entered code on confirma, evaluates the returned aut vector one
// cycle later, grants a timed access window at the highest matched level,
// counts consecutive failures and enforces a timed lockout.
//   clk, rst   : clock, asynchronous active-high reset
//   entradas   : raw code {A..F}, A = bit 5
//   confirma   : attempt request (level-sensitive, sampled each edge)
//   cancela    : closes the access window / discards a request in OCIOSO
//   codigo     : registered code driven to the comparator
//   aut        : comparator result {AUT3,AUT2,AUT1}, combinational from codigo
//   liberado   : access granted
//   nivel      : granted level (0 when not granted)
//   negado     : one-cycle pulse per failed attempt
//   bloqueado  : lockout active
//   falhas     : consecutive failed attempts
//   estado     : current FSM state, for debug/observation
//
// Handshake: there is no ready; a request is taken whenever the FSM is in
// OCIOSO at a rising edge with confirma=1 and cancela=0. Requests in any other
// state are dropped, not queued.
module controlador_autenticacao
  import autenticacao_pkg::*;
#(
  parameter int MAX_FALHAS  = 3,
  parameter int LIB_CICLOS  = 8,
  parameter int BLOQ_CICLOS = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [LARGURA_CODIGO-1:0]          entradas,
  input  logic                               confirma,
  input  logic                               cancela,
  output logic [LARGURA_CODIGO-1:0]          codigo,
  input  logic [LARGURA_AUT-1:0]             aut,
  output logic                               liberado,
  output logic [1:0]                         nivel,
  output logic                               negado,
  output logic                               bloqueado,
  output logic [$clog2(MAX_FALHAS+1)-1:0]    falhas,
  output logic [1:0]                         estado
);

  localparam int LARGURA_FALHAS = $clog2(MAX_FALHAS + 1);
  localparam int MAX_CICLOS     = (LIB_CICLOS > BLOQ_CICLOS) ? LIB_CICLOS : BLOQ_CICLOS;
  localparam int LARGURA_TEMP   = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;

  localparam logic [1:0] EST_OCIOSO    = 2'(OCIOSO);
  localparam logic [1:0] EST_AVALIA    = 2'(AVALIA);
  localparam logic [1:0] EST_LIBERADO  = 2'(LIBERADO);
  localparam logic [1:0] EST_BLOQUEADO = 2'(BLOQUEADO);

  // The timer is loaded with N-1 so the output stays high for exactly N cycles:
  // the exit edge is the one that sees zero.
  localparam logic [LARGURA_TEMP-1:0] CARGA_LIB  = LARGURA_TEMP'(LIB_CICLOS - 1);
  localparam logic [LARGURA_TEMP-1:0] CARGA_BLOQ = LARGURA_TEMP'(BLOQ_CICLOS - 1);

  logic                    aut_ok;
  logic                    falha_final;
  logic                    temp_carga;
  logic [LARGURA_TEMP-1:0] temp_valor_carga;
  logic                    temp_habilita;
  logic                    temp_zero;

  assign aut_ok      = (aut != '0);
  assign falha_final = ((int'(falhas) + 1) >= MAX_FALHAS);

  always_comb begin
    temp_carga       = 1'b0;
    temp_valor_carga = CARGA_LIB;
    temp_habilita    = 1'b0;
    if (estado == EST_AVALIA) begin
      temp_carga       = aut_ok || falha_final;
      temp_valor_carga = aut_ok ? CARGA_LIB : CARGA_BLOQ;
    end
    if ((estado == EST_LIBERADO) || (estado == EST_BLOQUEADO)) begin
      temp_habilita = 1'b1;
    end
  end

  temporizador_descendente #(
    .LARGURA (LARGURA_TEMP)
  ) u_temporizador (
    .clk         (clk),
    .rst         (rst),
    .carga       (temp_carga),
    .valor_carga (temp_valor_carga),
    .habilita    (temp_habilita),
    .zero        (temp_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= EST_OCIOSO;
      codigo    <= '0;
      liberado  <= 1'b0;
      nivel     <= NIVEL_NENHUM;
      negado    <= 1'b0;
      bloqueado <= 1'b0;
      falhas    <= '0;
    end else begin
      negado <= 1'b0;
      case (estado)
        EST_OCIOSO: begin
          // cancela wins over confirma.
          if (confirma && !cancela) begin
            codigo <= entradas;
            estado <= EST_AVALIA;
          end
        end

        EST_AVALIA: begin
          // codigo has had a full cycle to propagate through the comparator.
          if (aut_ok) begin
            nivel    <= codifica_nivel(aut);
            liberado <= 1'b1;
            falhas   <= '0;
            estado   <= EST_LIBERADO;
          end else if (falha_final) begin
            negado    <= 1'b1;
            bloqueado <= 1'b1;
            falhas    <= LARGURA_FALHAS'(MAX_FALHAS);
            estado    <= EST_BLOQUEADO;
          end else begin
            negado <= 1'b1;
            falhas <= falhas + LARGURA_FALHAS'(1);
            estado <= EST_OCIOSO;
          end
        end

        EST_LIBERADO: begin
          if (temp_zero || cancela) begin
            liberado <= 1'b0;
            nivel    <= NIVEL_NENHUM;
            estado   <= EST_OCIOSO;
          end
        end

        EST_BLOQUEADO: begin
          if (temp_zero) begin
            bloqueado <= 1'b0;
            falhas    <= '0;
            estado    <= EST_OCIOSO;
          end
        end

        default: estado <= EST_OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_autenticacao.sv
module tb_controlador_autenticacao;

  logic       clk;
  logic       rst;
  logic [5:0] entradas;
  logic       confirma;
  logic       cancela;
  logic [5:0] codigo;
  logic [2:0] aut;
  logic       liberado;
  logic [1:0] nivel;
  logic       negado;
  logic       bloqueado;
  logic [1:0] falhas;
  logic [1:0] estado;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt;

  controlador_autenticacao #(
    .MAX_FALHAS  (3),
    .LIB_CICLOS  (8),
    .BLOQ_CICLOS (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .entradas  (entradas),
    .confirma  (confirma),
    .cancela   (cancela),
    .codigo    (codigo),
    .aut       (aut),
    .liberado  (liberado),
    .nivel     (nivel),
    .negado    (negado),
    .bloqueado (bloqueado),
    .falhas    (falhas),
    .estado    (estado)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Comparator model: a handful of enrolled codes, everything else rejected.
  always_comb begin
    case (codigo)
      6'b011100: aut = 3'b100;
      6'b010101: aut = 3'b011;
      6'b000111: aut = 3'b001;
      default:   aut = 3'b000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Present a code for one edge, then sample the decision after the next edge.
  task automatic tentativa(input logic [5:0] c);
    entradas = c;
    confirma = 1'b1;
    step();
    check("codigo_capturado", 32'(codigo), 32'(c));
    confirma = 1'b0;
    entradas = ~c;
    step();
  endtask

  initial begin
    rst = 1'b1;
    entradas = '0;
    confirma = 1'b0;
    cancela = 1'b0;
    step();
    step();
    check("rst_codigo", 32'(codigo), 32'h0);
    check("rst_saidas", {liberado, nivel, negado, bloqueado, falhas}, 32'h0);
    rst = 1'b0;
    step();
    check("idle_saidas", {liberado, nivel, negado, bloqueado, falhas}, 32'h0);
    check("idle_estado", 32'(estado), 32'd0);

    // Grant at level 3 and measure the window.
    tentativa(6'b011100);
    check("grant_liberado", 32'(liberado), 32'd1);
    check("grant_nivel", 32'(nivel), 32'd3);
    check("grant_falhas", 32'(falhas), 32'd0);
    check("grant_codigo_estavel", 32'(codigo), 32'h1c);
    cnt = 0;
    while (liberado && cnt < 40) begin
      cnt++;
      step();
    end
    check("janela_ciclos", 32'(cnt), 32'd8);
    check("janela_fim_nivel", 32'(nivel), 32'd0);
    check("janela_fim_estado", 32'(estado), 32'd0);

    // Priority (aut=011 -> level 2) and cancel three cycles into the window.
    tentativa(6'b010101);
    check("prio_nivel", 32'(nivel), 32'd2);
    step();
    step();
    check("prio_ainda_liberado", 32'(liberado), 32'd1);
    cancela = 1'b1;
    step();
    cancela = 1'b0;
    check("cancela_liberado", 32'(liberado), 32'd0);
    check("cancela_nivel", 32'(nivel), 32'd0);
    check("cancela_estado", 32'(estado), 32'd0);

    // Three failures -> lockout.
    for (int k = 1; k <= 3; k++) begin
      tentativa(6'b111111);
      check("falha_negado", 32'(negado), 32'd1);
      check("falha_liberado", 32'(liberado), 32'd0);
      check("falha_contagem", 32'(falhas), 32'(k));
      check("falha_bloqueado", 32'(bloqueado), (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) begin
        step();
        check("negado_pulso", 32'(negado), 32'd0);
      end
    end
    // Requests during lockout must be ignored.
    entradas = 6'b011100;
    confirma = 1'b1;
    cancela = 1'b1;
    cnt = 1;
    step();
    check("bloq_negado_pulso", 32'(negado), 32'd0);
    while (bloqueado && cnt < 60) begin
      cnt++;
      step();
    end
    confirma = 1'b0;
    cancela = 1'b0;
    check("bloq_ciclos", 32'(cnt), 32'd16);
    check("bloq_fim_falhas", 32'(falhas), 32'd0);
    check("bloq_codigo_inalterado", 32'(codigo), 32'h3f);
    check("bloq_fim_estado", 32'(estado), 32'd0);
    step();
    check("pos_bloq_liberado", 32'(liberado), 32'd0);

    // Failure count cleared by a success.
    tentativa(6'b101010);
    check("fr_falhas1", 32'(falhas), 32'd1);
    step();
    tentativa(6'b101010);
    check("fr_falhas2", 32'(falhas), 32'd2);
    step();
    tentativa(6'b000111);
    check("fr_nivel1", 32'(nivel), 32'd1);
    check("fr_falhas_zero", 32'(falhas), 32'd0);
    cancela = 1'b1;
    step();
    cancela = 1'b0;
    tentativa(6'b101010);
    check("fr_falha_seguinte", 32'(falhas), 32'd1);
    check("fr_sem_bloqueio", 32'(bloqueado), 32'd0);
    step();

    // confirma and cancela together in OCIOSO: nothing happens.
    entradas = 6'b011100;
    confirma = 1'b1;
    cancela = 1'b1;
    step();
    check("simult_codigo", 32'(codigo), 32'h2a);
    check("simult_estado", 32'(estado), 32'd0);
    step();
    check("simult_saidas", {liberado, nivel, negado, bloqueado}, 32'h0);
    confirma = 1'b0;
    cancela = 1'b0;
    step();

    // Asynchronous reset in the middle of a window.
    tentativa(6'b011100);
    step();
    check("pre_rst_liberado", 32'(liberado), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_saidas", {liberado, nivel, negado, bloqueado, falhas}, 32'h0);
    check("rst_async_codigo", 32'(codigo), 32'h0);
    check("rst_async_estado", 32'(estado), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("pos_rst_idle", {liberado, nivel, negado, bloqueado, falhas}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
